// File: rtl/vrf_write_scheduler.sv
// Round-robin arbiter for the VRF write port with a registered output stage and a per-register
// pending-write scoreboard. Define VRF_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module vrf_write_scheduler #(
    parameter int NREQ   = 3,
    parameter int PEND_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][4:0]         req_addr,
    input  logic [NREQ-1:0][3:0][31:0]   req_data,
    input  logic [NREQ-1:0][3:0]         req_we,
    input  logic                         rsv_valid,
    input  logic [4:0]                   rsv_addr,
    output logic                         rsv_ready,
    output logic [31:0]                  busy,
    output logic [4:0]                   write_addr,
    output logic [3:0][31:0]             write_vector,
    output logic [3:0]                   we,
    output logic                         underflow_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                  grant_any;
    logic [IDX_W-1:0]      grant_idx;

    logic [4:0]            write_addr_reg;
    logic [3:0][31:0]      write_vector_reg;
    logic [3:0]            we_reg;
    logic                  ret_valid_reg;
    logic                  underflow_reg;

    logic [PEND_W-1:0]     cnt_reg  [32];
    logic [PEND_W-1:0]     cnt_next [32];
    logic [31:0]           uf_hit;
    logic                  rsv_hit;

`ifdef VRF_SCHED_FIXED_PRIO_EN
    // Walk from the highest index down so the lowest valid index is the last writer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0]      last_grant_reg;
    logic [IDX_W-1:0]      cand_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    // Farthest candidate first so the one nearest last_grant+1 overwrites and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_idx = wrap_idx(last_grant_reg, k);
            if (req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= IDX_W'(NREQ - 1);
        end else if (grant_any) begin
            last_grant_reg <= grant_idx;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & grant_any & (grant_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_addr_reg   <= '0;
            write_vector_reg <= '0;
            we_reg           <= '0;
            ret_valid_reg    <= 1'b0;
        end else begin
            ret_valid_reg <= grant_any;
            if (grant_any) begin
                write_addr_reg   <= req_addr[grant_idx];
                write_vector_reg <= req_data[grant_idx];
                we_reg           <= req_we[grant_idx];
            end else begin
                we_reg <= '0;
            end
        end
    end

    // A retirement to the reserved register frees a slot in the same cycle.
    assign rsv_ready = rst_n & ((cnt_reg[rsv_addr] != {PEND_W{1'b1}}) |
                                (ret_valid_reg & (write_addr_reg == rsv_addr)));
    assign rsv_hit   = rsv_valid & rsv_ready;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = rsv_hit & (rsv_addr == 5'(gi));
            assign dec = ret_valid_reg & (write_addr_reg == 5'(gi));
            assign cnt_next[gi] = (inc & ~dec) ? cnt_reg[gi] + PEND_W'(1) :
                                  (dec & ~inc & (cnt_reg[gi] != '0)) ? cnt_reg[gi] - PEND_W'(1) :
                                  cnt_reg[gi];
            assign uf_hit[gi] = dec & (cnt_reg[gi] == '0);
            assign busy[gi]   = |cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '{default: '0};
            underflow_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (|uf_hit) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign write_addr    = write_addr_reg;
    assign write_vector  = write_vector_reg;
    assign we            = we_reg;
    assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_vrf_write_scheduler.sv
// Randomized + directed bench for vrf_write_scheduler: a reference model pushes per-cycle
// expectations into a queue and a negedge monitor pops and compares them against the DUT.
module tb_vrf_write_scheduler;
    localparam int NREQ   = 3;
    localparam int PEND_W = 2;
    localparam int CMAX   = (1 << PEND_W) - 1;

    logic                        clk;
    logic                        rst_n;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][4:0]        req_addr;
    logic [NREQ-1:0][3:0][31:0]  req_data;
    logic [NREQ-1:0][3:0]        req_we;
    logic                        rsv_valid;
    logic [4:0]                  rsv_addr;
    logic                        rsv_ready;
    logic [31:0]                 busy;
    logic [4:0]                  write_addr;
    logic [3:0][31:0]            write_vector;
    logic [3:0]                  we;
    logic                        underflow_err;

    vrf_write_scheduler #(.NREQ(NREQ), .PEND_W(PEND_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_we(req_we),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .busy(busy), .write_addr(write_addr), .write_vector(write_vector),
        .we(we), .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] ready;
        logic            rsv_rdy;
        logic [4:0]      waddr;
        logic [127:0]    wvec;
        logic [3:0]      wen;
        logic [31:0]     busy_v;
        logic            uf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the values the DUT should be showing during the current cycle.
    int          m_cnt [32];
    int          m_last;
    bit          m_pres;
    logic [4:0]  m_waddr;
    logic [127:0] m_wvec;
    logic [3:0]  m_we;
    bit          m_uf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, want);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_last  = NREQ - 1;
        m_pres  = 0;
        m_waddr = '0;
        m_wvec  = '0;
        m_we    = '0;
        m_uf    = 0;
    endtask

    // Drive one cycle (called at posedge+1), push the expected outputs, advance the model.
    task automatic cycle(input logic rstn, input logic [NREQ-1:0] v, input logic rv,
                         input logic [4:0] ra, input bit push,
                         input bit lit_en, input logic [NREQ-1:0] lit);
        exp_t e;
        int   g;
        bit   acc;
        rst_n     = rstn;
        req_valid = v;
        rsv_valid = rv;
        rsv_addr  = ra;
        g = -1;
        if (rstn) begin
`ifdef VRF_SCHED_FIXED_PRIO_EN
            for (int i = 0; i < NREQ; i++) if (v[i] && g < 0) g = i;
`else
            for (int k = 1; k <= NREQ; k++) if (v[(m_last + k) % NREQ] && g < 0) g = (m_last + k) % NREQ;
`endif
        end
        e.ready   = (g >= 0) ? NREQ'(1 << g) : '0;
        e.rsv_rdy = rstn && ((m_cnt[ra] != CMAX) || (m_pres && m_waddr == ra));
        e.waddr   = m_waddr;
        e.wvec    = m_wvec;
        e.wen     = m_we;
        for (int r = 0; r < 32; r++) e.busy_v[r] = (m_cnt[r] != 0);
        e.uf      = m_uf;
        if (push) exp_q.push_back(e);

        if (!rstn) begin
            model_reset();
        end else begin
            acc = rv && e.rsv_rdy;
            if (m_pres && m_cnt[m_waddr] == 0) m_uf = 1;
            if (!(m_pres && acc && m_waddr == ra)) begin
                if (acc) m_cnt[ra] = m_cnt[ra] + 1;
                if (m_pres && m_cnt[m_waddr] > 0) m_cnt[m_waddr] = m_cnt[m_waddr] - 1;
            end
            if (g >= 0) begin
                m_pres  = 1;
                m_waddr = req_addr[g];
                m_wvec  = req_data[g];
                m_we    = req_we[g];
                m_last  = g;
            end else begin
                m_pres = 0;
                m_we   = '0;
            end
        end
        #2;
        if (lit_en) chk("t1_grant", 128'(req_ready), 128'(lit));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_reqs(input int amax);
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = 5'($urandom_range(amax, 0));
            req_we[i]   = ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom);
            for (int l = 0; l < 4; l++) req_data[i][l] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, 1'b0, 5'd0, 1, 0, '0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 5'd0, 1, 0, '0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("req_ready", 128'(req_ready), 128'(e.ready));
            chk("rsv_ready", 128'(rsv_ready), 128'(e.rsv_rdy));
            chk("write_addr", 128'(write_addr), 128'(e.waddr));
            chk("write_vector", 128'(write_vector), e.wvec);
            chk("we", 128'(we), 128'(e.wen));
            chk("busy", 128'(busy), 128'(e.busy_v));
            chk("underflow_err", 128'(underflow_err), 128'(e.uf));
        end
    end

    logic [NREQ-1:0] t1_seq [6];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        req_addr  = '0;
        req_data  = '0;
        req_we    = '0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b0, 5'd0, 0, 0, '0);
        cycle(1'b0, '0, 1'b0, 5'd0, 0, 0, '0);
        model_reset();

        // 1: all requesters valid for 6 cycles
`ifdef VRF_SCHED_FIXED_PRIO_EN
        t1_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        t1_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = 5'(20 + i);
            req_we[i]   = 4'hF;
            for (int l = 0; l < 4; l++) req_data[i][l] = $urandom;
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'b111, 1'b0, 5'd0, 1, 1, t1_seq[i]);
        idle(2);
        do_reset();

        // 2: reserve r5, then requester 1 writes r5 with we=0101
        cycle(1'b1, '0, 1'b1, 5'd5, 1, 0, '0);
        req_addr[1] = 5'd5;
        req_we[1]   = 4'b0101;
        cycle(1'b1, 3'b010, 1'b0, 5'd0, 1, 0, '0);
        idle(3);

        // 3: saturate r7, 4th attempt held until r7's write retires
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, 1'b1, 5'd7, 1, 0, '0);
        req_addr[2] = 5'd7;
        req_we[2]   = 4'hF;
        cycle(1'b1, 3'b100, 1'b1, 5'd7, 1, 0, '0);
        cycle(1'b1, '0, 1'b1, 5'd7, 1, 0, '0);
        idle(2);
        do_reset();

        // 4: reserve r9, write r9, reserve r9 again while the write retires
        cycle(1'b1, '0, 1'b1, 5'd9, 1, 0, '0);
        cycle(1'b1, '0, 1'b1, 5'd9, 1, 0, '0);
        req_addr[0] = 5'd9;
        req_we[0]   = 4'hA;
        cycle(1'b1, 3'b001, 1'b0, 5'd0, 1, 0, '0);
        cycle(1'b1, '0, 1'b1, 5'd9, 1, 0, '0);
        idle(2);
        do_reset();

        // 5: unreserved write to r3 raises sticky underflow
        req_addr[0] = 5'd3;
        req_we[0]   = 4'hF;
        cycle(1'b1, 3'b001, 1'b0, 5'd0, 1, 0, '0);
        idle(4);

        // 6: reset in the cycle after a grant
        cycle(1'b1, 3'b010, 1'b0, 5'd0, 1, 0, '0);
        cycle(1'b0, 3'b111, 1'b1, 5'd1, 1, 0, '0);
        cycle(1'b1, 3'b111, 1'b0, 5'd0, 1, 0, '0);
        idle(2);

        // Random traffic on a small register window to provoke hazards and saturation.
        for (int n = 0; n < 3000; n++) begin
            rand_reqs(7);
            cycle(($urandom_range(249, 0) != 0), NREQ'($urandom),
                  ($urandom_range(2, 0) != 0), 5'($urandom_range(7, 0)), 1, 0, '0);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
